// File: rtl/regfile_pkg.sv
// regfile_pkg: shared width defaults, sweep state type and the port-field slicing helper.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;
  typedef enum logic {INIT, RUN} state_e;
  function automatic int fld_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register saturating pending-write counters,
// issue acceptance, busy lookup for read ports, and flush.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int NISSUE = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     run_i,
  input  logic                     flush_i,
  input  logic [NWRITE-1:0]        we_i,
  input  logic [NWRITE*ADDR_W-1:0] waddr_i,
  input  logic [NISSUE-1:0]        iss_v_i,
  input  logic [NISSUE*ADDR_W-1:0] iss_addr_i,
  input  logic [NREAD*ADDR_W-1:0]  raddr_i,
  output logic [NISSUE-1:0]        iss_ok_o,
  output logic [NREAD-1:0]         rbusy_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXC  = (1 << PEND_W) - 1;
  logic [PEND_W-1:0] cnt_q [DEPTH];
  logic [PEND_W-1:0] cnt_d [DEPTH];
  logic [ADDR_W-1:0] wa [NWRITE];
  logic [ADDR_W-1:0] ia [NISSUE];
  logic [ADDR_W-1:0] ra [NREAD];
  logic [DEPTH-1:0]  clr;
  for (genvar k = 0; k < NWRITE; k++) begin : g_wa
    assign wa[k] = waddr_i[fld_lo(k, ADDR_W) +: ADDR_W];
  end
  for (genvar j = 0; j < NISSUE; j++) begin : g_ia
    assign ia[j] = iss_addr_i[fld_lo(j, ADDR_W) +: ADDR_W];
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_ra
    assign ra[i] = raddr_i[fld_lo(i, ADDR_W) +: ADDR_W];
  end
  // Same-cycle clears are deliberately not credited here to keep the accept path short.
  always_comb begin
    logic [NISSUE-1:0] ok;
    int n;
    ok = '0;
    n = 0;
    for (int j = 0; j < NISSUE; j++) begin
      n = 0;
      for (int p = 0; p < j; p++)
        n += (ok[p] && ia[p] == ia[j]) ? 1 : 0;
      ok[j] = run_i && iss_v_i[j] && (ia[j] == '0 || int'(cnt_q[ia[j]]) + n < MAXC);
    end
    iss_ok_o = ok;
  end
  always_comb begin
    int sets;
    sets = 0;
    for (int r = 0; r < DEPTH; r++) begin
      clr[r] = 1'b0;
      sets = 0;
      for (int k = 0; k < NWRITE; k++)
        clr[r] |= we_i[k] && wa[k] == ADDR_W'(r);
      for (int j = 0; j < NISSUE; j++)
        sets += (iss_ok_o[j] && ia[j] == ADDR_W'(r)) ? 1 : 0;
      cnt_d[r] = (flush_i || r == 0) ? '0
               : PEND_W'(int'(cnt_q[r]) + sets - ((clr[r] && cnt_q[r] != '0) ? 1 : 0));
    end
  end
  always_comb begin
    rbusy_o = '0;
    for (int i = 0; i < NREAD; i++)
      rbusy_o[i] = run_i && ra[i] != '0 && cnt_q[ra[i]] > PEND_W'(clr[ra[i]]);
  end
  always_ff @(posedge clk)
    if (!aresetn) for (int r = 0; r < DEPTH; r++) cnt_q[r] <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-to-read bypass, post-reset
// clearing sweep and an integrated pending-write scoreboard.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int NISSUE = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     aresetn,
  output logic                     ready,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NISSUE-1:0]        iss_v,
  input  logic [NISSUE*ADDR_W-1:0] iss_addr,
  output logic [NISSUE-1:0]        iss_ok,
  input  logic                     flush
);
  localparam int DEPTH = 1 << ADDR_W;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wa [NWRITE];
  logic [DATA_W-1:0] wd [NWRITE];
  logic              run;
  logic [NWRITE-1:0] we_run;
  for (genvar k = 0; k < NWRITE; k++) begin : g_w
    assign wa[k] = waddr[fld_lo(k, ADDR_W) +: ADDR_W];
    assign wd[k] = wdata[fld_lo(k, DATA_W) +: DATA_W];
  end
  assign run    = aresetn && state_q == RUN;
  assign ready  = run;
  assign we_run = run ? we : '0;
  always_comb begin
    state_d = (state_q == INIT && &idx_q) ? RUN : state_q;
    idx_d   = (state_q == INIT) ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk)
    if (!aresetn) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  // Later ports overwrite earlier ones on the same address; register 0 is never written.
  always_ff @(posedge clk)
    if (aresetn) begin
      if (state_q == INIT) mem_q[idx_q] <= '0;
      else for (int k = 0; k < NWRITE; k++) if (we[k] && wa[k] != '0) mem_q[wa[k]] <= wd[k];
    end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] v;
    assign ra = raddr[fld_lo(i, ADDR_W) +: ADDR_W];
    always_comb begin
      v = mem_q[ra];
      for (int k = 0; k < NWRITE; k++) v = (we[k] && wa[k] == ra) ? wd[k] : v;
    end
    assign rdata[fld_lo(i, DATA_W) +: DATA_W] = (run && ra != '0) ? v : '0;
  end
  regfile_scoreboard #(
    .NREAD(NREAD), .NWRITE(NWRITE), .NISSUE(NISSUE), .ADDR_W(ADDR_W), .PEND_W(PEND_W)
  ) u_sb (
    .clk       (clk),
    .aresetn   (aresetn),
    .run_i     (run),
    .flush_i   (flush && run),
    .we_i      (we_run),
    .waddr_i   (waddr),
    .iss_v_i   (iss_v),
    .iss_addr_i(iss_addr),
    .raddr_i   (raddr),
    .iss_ok_o  (iss_ok),
    .rbusy_o   (rbusy)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed scenarios plus random traffic checked against a
// behavioural register-file/scoreboard model.
module tb_regfile_mp_sb;
  localparam int NR = 4, NW = 2, NI = 2, DW = 32, AW = 5, PW = 2;
  localparam int DEPTH = 32, MAXC = 3;
  logic clk = 0, aresetn = 0, flush = 0, ready;
  logic [NW-1:0] we = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic [NI-1:0] iss_v = '0, iss_ok;
  logic [NI*AW-1:0] iss_addr = '0;
  int total = 0, bad = 0;
  logic [DW-1:0] m_reg [DEPTH];
  int m_cnt [DEPTH];
  int m_init = 0;
  logic [NI-1:0] exp_ok = '0;
  always #5 clk = ~clk;
  regfile_mp_sb #(.NREAD(NR), .NWRITE(NW), .NISSUE(NI), .DATA_W(DW), .ADDR_W(AW), .PEND_W(PW)) dut (
    .clk(clk), .aresetn(aresetn), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_v(iss_v), .iss_addr(iss_addr),
    .iss_ok(iss_ok), .flush(flush)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int wa(input int k); return int'(waddr[k*AW +: AW]); endfunction
  function automatic int ia(input int j); return int'(iss_addr[j*AW +: AW]); endfunction
  function automatic int ra(input int i); return int'(raddr[i*AW +: AW]); endfunction
  function automatic bit wb(input int a);
    for (int k = 0; k < NW; k++) if (we[k] && wa(k) == a) return 1;
    return 0;
  endfunction
  task automatic check_outputs();
    logic [NR*DW-1:0] e_rd;
    logic [NR-1:0] e_rb;
    bit run;
    e_rd = '0;
    e_rb = '0;
    exp_ok = '0;
    run = aresetn && m_init == DEPTH;
    if (run) begin
      for (int i = 0; i < NR; i++) begin
        logic [DW-1:0] d;
        d = m_reg[ra(i)];
        for (int k = 0; k < NW; k++) if (we[k] && wa(k) == ra(i)) d = wdata[k*DW +: DW];
        e_rd[i*DW +: DW] = (ra(i) == 0) ? '0 : d;
        e_rb[i] = ra(i) != 0 && m_cnt[ra(i)] - int'(wb(ra(i))) > 0;
      end
      for (int j = 0; j < NI; j++) begin
        int n;
        n = 0;
        for (int p = 0; p < j; p++) if (exp_ok[p] && ia(p) == ia(j)) n++;
        exp_ok[j] = iss_v[j] && (ia(j) == 0 || m_cnt[ia(j)] + n + 1 <= MAXC);
      end
    end
    chk("ready", ready, run);
    chk("rdata", rdata, e_rd);
    chk("rbusy", rbusy, e_rb);
    chk("iss_ok", iss_ok, exp_ok);
  endtask
  task automatic model_edge();
    if (!aresetn) begin
      m_init = 0;
      for (int r = 0; r < DEPTH; r++) m_cnt[r] = 0;
    end else if (m_init < DEPTH) begin
      m_reg[m_init] = '0;
      m_init++;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        int nxt;
        nxt = m_cnt[r] - int'(wb(r));
        if (nxt < 0) nxt = 0;
        for (int j = 0; j < NI; j++) if (exp_ok[j] && ia(j) == r) nxt++;
        m_cnt[r] = flush ? 0 : nxt;
      end
      for (int k = 0; k < NW; k++) if (we[k] && wa(k) != 0) m_reg[wa(k)] = wdata[k*DW +: DW];
    end
  endtask
  task automatic settle(); @(negedge clk); check_outputs(); endtask
  task automatic edge_(); @(posedge clk); model_edge(); #1; endtask
  task automatic cyc(); settle(); edge_(); endtask
  task automatic idle(); we = '0; iss_v = '0; flush = 0; endtask
  task automatic wr(input int k, input int a, input logic [DW-1:0] d);
    we[k] = 1'b1; waddr[k*AW +: AW] = AW'(a); wdata[k*DW +: DW] = d;
  endtask
  task automatic rd(input int i, input int a); raddr[i*AW +: AW] = AW'(a); endtask
  task automatic iss(input int j, input int a); iss_v[j] = 1'b1; iss_addr[j*AW +: AW] = AW'(a); endtask
  task automatic junk(); idle(); wr(0, 7, 32'hdead_beef); iss(0, 7); flush = 1; rd(0, 7); endtask
  initial begin
    for (int r = 0; r < DEPTH; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    cyc(); cyc();
    aresetn = 1;
    for (int c = 0; c < 10; c++) begin junk(); cyc(); end
    aresetn = 0; cyc();
    aresetn = 1;
    for (int c = 0; c < 32; c++) begin junk(); settle(); chk("sweep_ready_lo", ready, 1'b0); edge_(); end
    idle(); rd(0, 7);
    settle(); chk("sweep_ready_hi", ready, 1'b1); chk("r7_zero", rdata[31:0], 32'h0); edge_();
    wr(0, 5, 32'h11); wr(1, 5, 32'h22); rd(0, 5);
    settle(); chk("bypass_prio", rdata[31:0], 32'h22); edge_();
    idle();
    settle(); chk("array_prio", rdata[31:0], 32'h22); edge_();
    wr(0, 0, 32'hff); rd(1, 0);
    settle(); chk("r0_bypass", rdata[63:32], 32'h0); edge_();
    idle();
    settle(); chk("r0_array", rdata[63:32], 32'h0); edge_();
    for (int c = 0; c < 3; c++) begin
      iss(0, 3); settle(); chk("sat_ok", iss_ok[0], 1'b1); edge_();
    end
    iss(0, 3); settle(); chk("sat_full", iss_ok[0], 1'b0); edge_();
    idle(); wr(0, 3, 32'h3); cyc();
    idle(); iss(0, 3); iss(1, 3);
    settle(); chk("sat_dual", iss_ok, 2'b01); edge_();
    idle(); wr(1, 3, 32'h33); cyc(); cyc(); cyc();
    idle(); iss(0, 4); cyc();
    iss(0, 4); wr(0, 4, 32'h44); rd(0, 4);
    settle(); chk("setclr_busy", rbusy[0], 1'b0); edge_();
    idle();
    settle(); chk("setclr_after", rbusy[0], 1'b1); edge_();
    iss(0, 1); iss(1, 1); cyc();
    idle(); iss(0, 2); cyc();
    idle(); iss(0, 9); flush = 1; wr(0, 12, 32'habc); cyc();
    idle(); rd(0, 1); rd(1, 2); rd(2, 9); rd(3, 12);
    settle(); chk("flush_busy", rbusy, 4'b0); chk("flush_write", rdata[127:96], 32'habc); edge_();
    wr(0, 6, 32'h66); rd(0, 6);
    settle(); chk("uf_busy", rbusy[0], 1'b0); edge_();
    idle();
    settle(); chk("uf_cnt", rbusy[0], 1'b0); chk("uf_data", rdata[31:0], 32'h66); edge_();
    for (int c = 0; c < 3000; c++) begin
      we = NW'($urandom);
      iss_v = NI'($urandom);
      flush = $urandom_range(15) == 0;
      for (int k = 0; k < NW; k++) begin
        waddr[k*AW +: AW] = AW'($urandom_range(7));
        wdata[k*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NI; j++) iss_addr[j*AW +: AW] = AW'($urandom_range(7));
      for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = AW'($urandom_range(7));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard, for the multi-issue pipeline. It provides NREAD combinational read ports and NWRITE writeback ports. Same-cycle write-to-read bypass gives the higher-indexed write port priority. A per-register saturating pending counter replaces the decode-stage busy logic. After reset, the array is cleared by a hardware sweep, and `ready` gates all use until the sweep finishes.

## Interface
- NREAD, 4, number of read ports
- NWRITE, 2, number of writeback ports
- NISSUE, 2, number of issue (busy-set) ports
- DATA_W, 32, register width
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2^PEND_W-1
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- ready  out  1  high once the init sweep has finished
- we  in  NWRITE  write enables
- waddr  in  NWRITE*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
- wdata  in  NWRITE*DATA_W  write data
- raddr  in  NREAD*ADDR_W  read addresses
- rdata  out  NREAD*DATA_W  read data
- rbusy  out  NREAD  read register still has writes pending after this cycle's writebacks
- iss_v  in  NISSUE  issue requests, one pending write each
- iss_addr  in  NISSUE*ADDR_W  issue destination registers
- iss_ok  out  NISSUE  issue accepted
- flush  in  1  pipeline flush; clears all pending counters

## Operation
- The design is clocked on clk. Reset is aresetn, synchronous and active-low.
- **States:** INIT and RUN.
  - Reset moves the block to INIT with sweep index 0 and all pending counters cleared.
  - In INIT, one register is written to 0 per cycle, at addresses 0 up to 2^ADDR_W-1.
  - After the last address, the block moves to RUN.
  - Reset asserted mid-sweep or in RUN restarts INIT at index 0.
- **Outputs during reset and INIT:**
  - `ready` = 0.
  - `rdata` = 0 and `rbusy` = 0.
  - `iss_ok` = 0.
  - `we` and `flush` are ignored.
- **Register 0:** always reads 0. Writes to it are dropped. Issues to it are accepted (iss_ok=1) but do not change its counter, which stays 0. rbusy for register 0 is always 0.
- **Writes:** the array updates at the clock edge. When several ports write the same address, the highest-indexed port wins and the others are dropped for that address.
- **Reads:** combinational, in this priority order:
  1. Register 0 → 0.
  2. Highest-indexed enabled write port whose address matches → its wdata.
  3. Otherwise → array contents.
- **Pending counter per register**, with next = cur + sets − clears:
  - Sets: accepted issues to that register this cycle, counting duplicates across issue ports.
  - Clears: writebacks to that register this cycle, at most one after the dropped-duplicate rule.
  - A clear when cur = 0 has no effect; the counter never underflows.
- **iss_ok[j]:** high if cur plus the number of lower-indexed accepted issues to the same address plus 1 ≤ 2^PEND_W−1. Same-cycle clears are not credited, which keeps the path short.
- **rbusy[i]:** equals (cur − clear_this_cycle) ≠ 0 for raddr[i]. Same-cycle issues are not included.
- **Flush:** all counters become 0 at the next edge, and same-cycle sets are discarded. Writes still commit.

## Timing
- Read latency is 0 cycles, with a combinational bypass from we/wdata.
- A write appears in the array at edge N+1 and is visible to the same-cycle read through the bypass.
- An issue accepted in cycle N makes rbusy visible from cycle N+1.
- The INIT sweep takes exactly 2^ADDR_W cycles after reset is released. `ready` rises in the cycle after the last sweep write.
- Nothing is registered on any output path except `ready` and the internal state.

## Structure
- Package `regfile_pkg`:
  - defaults for DATA_W, ADDR_W and PEND_W;
  - state enum {INIT, RUN};
  - the helper function for port field slicing.
- Sub-module `regfile_scoreboard` holds:
  - the pending counters;
  - iss_ok generation;
  - the rbusy lookup;
  - flush.
- The top level holds:
  - the array;
  - the bypass network;
  - the INIT FSM;
  - the scoreboard instance.

## Test plan
- **Reset sweep:** release aresetn → ready=0 for 32 cycles and 1 on cycle 33; reading r7 then gives 0. Asserting reset at sweep index 10 restarts the 32-cycle count.
- **Bypass priority:** write port 0 r5←0x11 and port 1 r5←0x22 in the same cycle → rdata for r5 = 0x22 that cycle and the next. Writing r0←0xFF → reads 0.
- **Saturation:** with PEND_W=2, issue r3 three times → iss_ok high each time. A fourth issue → iss_ok=0. A double issue to r3 from count 2 → port 0 ok, port 1 refused.
- **Set/clear same cycle:** r4 count=1 with issue r4 and writeback r4 in the same cycle → rbusy(r4)=0 that cycle and count=1 after the edge.
- **Flush:** r1=2, r2=1 and a same-cycle issue to r9 with flush → all rbusy are 0 next cycle, and a write in the flush cycle commits.
- **Underflow:** writeback r6 with count 0 → count stays 0 and the data commits.
